fa16_rev_feed: RTL and testbench

- Bidirectional elastic staging buffer directly upstream of the 16-bit reversible adder stage.
- Forward mode: accepts operand tuples {A, B, C0_f, Z} from the producer and presents them to the adder's forward inputs.
- Backward mode: accepts recovered tuples {A, B, C0_f, Z} from the adder's reverse outputs and returns them to the producer.
- Owns the pipeline direction bit and changes it only when the buffer is drained.

---
 rtl/fa16_rev_feed.sv | 230 +++++++++++++++++++++++
 tb/tb_fa16_rev_feed.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fa16_rev_feed.sv
// ---------------------------------------------------------------------------
// fa16_rev_feed
//
// Bidirectional elastic staging buffer that sits in front of the 16-bit
// reversible adder. In forward mode it queues operand tuples {a, b, c0, z}
// from the producer and hands them to the adder's forward inputs. In backward
// mode it queues recovered tuples from the adder's reverse outputs and returns
// them to the producer. A single circular FIFO is shared by both directions,
// so the direction bit only changes when the FIFO is empty.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   vdd, vss            power pins (only with USE_POWER_PINS)
//   dir_req             requested direction (0 = forward, 1 = backward)
//   dir, switching      current direction / one-cycle switch indicator
//   up_*                forward tuple in from producer   (valid/ready)
//   dn_*                forward tuple out to adder       (valid/ready)
//   bk_in_*             recovered tuple in from adder    (valid/ready)
//   bk_out_*            recovered tuple out to producer  (valid/ready)
//   inflight            dn fires minus bk_in fires, modulo 2^CNT_W
// ---------------------------------------------------------------------------
//  state   | meaning
//  S_FWD   | forward streaming: up_* -> FIFO -> dn_*
//  S_SWITCH| one-cycle turnaround, FIFO empty, all handshakes idle
//  S_BWD   | backward streaming: bk_in_* -> FIFO -> bk_out_*
// ---------------------------------------------------------------------------
module fa16_rev_feed #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
`ifdef USE_POWER_PINS
  inout  wire              vdd,
  inout  wire              vss,
`endif
  input  logic             clk,
  input  logic             rst,

  input  logic             dir_req,
  output logic             dir,
  output logic             switching,

  input  logic             up_valid,
  output logic             up_ready,
  input  logic [15:0]      up_a,
  input  logic [15:0]      up_b,
  input  logic             up_c0,
  input  logic             up_z,

  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [15:0]      dn_a,
  output logic [15:0]      dn_b,
  output logic             dn_c0,
  output logic             dn_z,

  input  logic             bk_in_valid,
  output logic             bk_in_ready,
  input  logic [15:0]      bk_in_a,
  input  logic [15:0]      bk_in_b,
  input  logic             bk_in_c0,
  input  logic             bk_in_z,

  output logic             bk_out_valid,
  input  logic             bk_out_ready,
  output logic [15:0]      bk_out_a,
  output logic [15:0]      bk_out_b,
  output logic             bk_out_c0,
  output logic             bk_out_z,

  output logic [CNT_W-1:0] inflight
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_FWD    = 2'd0,
    S_SWITCH = 2'd1,
    S_BWD    = 2'd2
  } state_t;

  state_t           state_q;
  logic             dir_q;
  logic             switching_q;
  // Holds all readys low during reset and releases them one cycle later.
  logic             live_q;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [33:0]      mem_q [DEPTH];

  logic             is_fwd, is_bwd;
  logic             not_full, not_empty;
  logic             up_fire, dn_fire, bk_in_fire, bk_out_fire;
  logic             wr_fire, rd_fire;
  logic [33:0]      wr_data, head;
  logic [33:0]      dn_data, bk_data;

  // ---------------------------------------------------------------------
  // Handshake generation
  // ---------------------------------------------------------------------
  assign is_fwd    = (state_q == S_FWD);
  assign is_bwd    = (state_q == S_BWD);
  // No full-bypass: a full FIFO refuses writes even when a read fires.
  assign not_full  = live_q && (count_q < CNT_FULL);
  assign not_empty = (count_q != '0);

  assign up_ready     = is_fwd && not_full;
  assign bk_in_ready  = is_bwd && not_full;
  assign dn_valid     = is_fwd && not_empty;
  assign bk_out_valid = is_bwd && not_empty;

  assign up_fire     = up_valid    && up_ready;
  assign bk_in_fire  = bk_in_valid && bk_in_ready;
  assign dn_fire     = dn_valid    && dn_ready;
  assign bk_out_fire = bk_out_valid && bk_out_ready;

  assign wr_fire = up_fire || bk_in_fire;
  assign rd_fire = dn_fire || bk_out_fire;

  assign wr_data = is_bwd ? {bk_in_a, bk_in_b, bk_in_c0, bk_in_z}
                          : {up_a, up_b, up_c0, up_z};

  // ---------------------------------------------------------------------
  // Read data: head entry straight from storage, zeroed when not valid
  // ---------------------------------------------------------------------
  assign head    = mem_q[rd_ptr_q];
  assign dn_data = dn_valid     ? head : '0;
  assign bk_data = bk_out_valid ? head : '0;

  assign dn_a      = dn_data[33:18];
  assign dn_b      = dn_data[17:2];
  assign dn_c0     = dn_data[1];
  assign dn_z      = dn_data[0];

  assign bk_out_a  = bk_data[33:18];
  assign bk_out_b  = bk_data[17:2];
  assign bk_out_c0 = bk_data[1];
  assign bk_out_z  = bk_data[0];

  assign dir       = dir_q;
  assign switching = switching_q;
  assign inflight  = inflight_q;

  // ---------------------------------------------------------------------
  // Next-state for pointers, occupancy and in-flight counter
  // ---------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_fire) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // dn and bk_in fires belong to different states, so they never coincide.
  always_comb begin
    inflight_d = inflight_q;
    if (dn_fire)         inflight_d = inflight_q + CNT_W'(1);
    else if (bk_in_fire) inflight_d = inflight_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      live_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      live_q     <= 1'b1;
    end
  end

  // Storage contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_data;
  end

  // ---------------------------------------------------------------------
  // Direction FSM. A switch is only taken on an empty FIFO with no write
  // landing this cycle, so the shared storage never mixes directions.
  // dir_q is flipped on SWITCH exit and also tells SWITCH where to go.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_FWD;
      dir_q       <= 1'b0;
      switching_q <= 1'b0;
    end else begin
      case (state_q)
        S_FWD: begin
          if (dir_req && !not_empty && !wr_fire) begin
            state_q     <= S_SWITCH;
            switching_q <= 1'b1;
          end
        end
        S_BWD: begin
          if (!dir_req && !not_empty && !wr_fire) begin
            state_q     <= S_SWITCH;
            switching_q <= 1'b1;
          end
        end
        S_SWITCH: begin
          state_q     <= dir_q ? S_FWD : S_BWD;
          dir_q       <= ~dir_q;
          switching_q <= 1'b0;
        end
        default: begin
          state_q     <= S_FWD;
          dir_q       <= 1'b0;
          switching_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fa16_rev_feed.sv
module tb_fa16_rev_feed;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dir_req = 1'b0;
  logic        dir, switching;
  logic        up_valid = 1'b0, up_ready;
  logic [15:0] up_a = '0, up_b = '0;
  logic        up_c0 = 1'b0, up_z = 1'b0;
  logic        dn_valid, dn_ready = 1'b0;
  logic [15:0] dn_a, dn_b;
  logic        dn_c0, dn_z;
  logic        bk_in_valid = 1'b0, bk_in_ready;
  logic [15:0] bk_in_a = '0, bk_in_b = '0;
  logic        bk_in_c0 = 1'b0, bk_in_z = 1'b0;
  logic        bk_out_valid, bk_out_ready = 1'b0;
  logic [15:0] bk_out_a, bk_out_b;
  logic        bk_out_c0, bk_out_z;
  logic [15:0] inflight;

  int errors = 0;
  int checks = 0;
  logic [33:0] q_dn[$];
  logic [33:0] q_bk[$];

  fa16_rev_feed #(.DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .dir_req(dir_req), .dir(dir), .switching(switching),
    .up_valid(up_valid), .up_ready(up_ready), .up_a(up_a), .up_b(up_b),
    .up_c0(up_c0), .up_z(up_z),
    .dn_valid(dn_valid), .dn_ready(dn_ready), .dn_a(dn_a), .dn_b(dn_b),
    .dn_c0(dn_c0), .dn_z(dn_z),
    .bk_in_valid(bk_in_valid), .bk_in_ready(bk_in_ready), .bk_in_a(bk_in_a),
    .bk_in_b(bk_in_b), .bk_in_c0(bk_in_c0), .bk_in_z(bk_in_z),
    .bk_out_valid(bk_out_valid), .bk_out_ready(bk_out_ready),
    .bk_out_a(bk_out_a), .bk_out_b(bk_out_b), .bk_out_c0(bk_out_c0),
    .bk_out_z(bk_out_z),
    .inflight(inflight)
  );

  always #5 clk = ~clk;

  function automatic logic [33:0] pk(input logic [15:0] a, input logic [15:0] b,
                                     input logic c, input logic z);
    return {a, b, c, z};
  endfunction

  task automatic chk(input string nm, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting (t=%0t)", nm, $time);
  endtask

  // Scoreboard monitor: a handshake seen at the falling edge fires at the
  // following rising edge, so the tuple presented now is the one consumed.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && dn_valid && dn_ready) begin
        if (q_dn.size() == 0) timeout("dn_unexpected_tuple");
        else chk("dn_tuple", {dn_a, dn_b, dn_c0, dn_z}, q_dn.pop_front());
      end
      if (!rst && bk_out_valid && bk_out_ready) begin
        if (q_bk.size() == 0) timeout("bk_out_unexpected_tuple");
        else chk("bk_out_tuple", {bk_out_a, bk_out_b, bk_out_c0, bk_out_z}, q_bk.pop_front());
      end
    end
  end

  // Returns #1 after the rising edge on which the tuple was accepted.
  task automatic push_up(input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic z);
    logic rdy;
    up_a = a; up_b = b; up_c0 = c; up_z = z; up_valid = 1'b1;
    q_dn.push_back(pk(a, b, c, z));
    rdy = 1'b0;
    for (int n = 0; n < 50 && !rdy; n++) begin
      @(negedge clk);
      rdy = up_ready;
      @(posedge clk);
    end
    #1 up_valid = 1'b0;
    if (!rdy) timeout("push_up");
  endtask

  task automatic push_bk(input logic [15:0] a, input logic [15:0] b,
                         input logic c, input logic z);
    logic rdy;
    bk_in_a = a; bk_in_b = b; bk_in_c0 = c; bk_in_z = z; bk_in_valid = 1'b1;
    q_bk.push_back(pk(a, b, c, z));
    rdy = 1'b0;
    for (int n = 0; n < 50 && !rdy; n++) begin
      @(negedge clk);
      rdy = bk_in_ready;
      @(posedge clk);
    end
    #1 bk_in_valid = 1'b0;
    if (!rdy) timeout("push_bk");
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && (q_dn.size() != 0 || q_bk.size() != 0); n++)
      @(negedge clk);
    @(posedge clk);
    #1;
    if (q_dn.size() != 0 || q_bk.size() != 0) timeout("drain");
  endtask

  // Ends on the falling edge where switching is first seen high.
  task automatic wait_sw();
    logic seen;
    seen = 1'b0;
    for (int n = 0; n < 30 && !seen; n++) begin
      @(negedge clk);
      seen = switching;
    end
    if (!seen) timeout("wait_switching");
  endtask

  initial begin
    // Reset state
    #3;
    chk1("rst_up_ready", up_ready, 1'b0);
    chk1("rst_dir", dir, 1'b0);
    chk1("rst_switching", switching, 1'b0);
    chk1("rst_dn_valid", dn_valid, 1'b0);
    chk16("rst_inflight", inflight, 16'h0000);
    #9 rst = 1'b0;
    @(posedge clk); #1;
    chk1("up_ready_after_release", up_ready, 1'b1);

    // Forward streaming
    dn_ready = 1'b1;
    push_up(16'h1234, 16'h0F0F, 1'b1, 1'b0);
    chk1("fwd_latency_valid", dn_valid, 1'b1);
    chk("fwd_latency_tuple1", {dn_a, dn_b, dn_c0, dn_z}, pk(16'h1234, 16'h0F0F, 1'b1, 1'b0));
    push_up(16'hFFFF, 16'h0001, 1'b0, 1'b1);
    chk("fwd_latency_tuple2", {dn_a, dn_b, dn_c0, dn_z}, pk(16'hFFFF, 16'h0001, 1'b0, 1'b1));
    drain();
    chk16("inflight_after_stream", inflight, 16'd2);

    // Backpressure: two accepted, third held while the head stays stable
    dn_ready = 1'b0;
    push_up(16'hAAAA, 16'h5555, 1'b0, 1'b0);
    push_up(16'hBBBB, 16'h4444, 1'b1, 1'b1);
    up_a = 16'hCCCC; up_b = 16'h3333; up_c0 = 1'b0; up_z = 1'b1; up_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("full_up_ready", up_ready, 1'b0);
      chk1("stall_dn_valid", dn_valid, 1'b1);
      chk("stall_head_stable", {dn_a, dn_b, dn_c0, dn_z}, pk(16'hAAAA, 16'h5555, 1'b0, 1'b0));
    end
    @(posedge clk); #1;
    dn_ready = 1'b1;
    push_up(16'hCCCC, 16'h3333, 1'b0, 1'b1);
    drain();
    chk16("inflight_after_backpressure", inflight, 16'd5);

    // Direction switch waits for drain
    dn_ready = 1'b0;
    push_up(16'h1234, 16'h0F0F, 1'b1, 1'b0);
    dir_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("hold_fwd_dir", dir, 1'b0);
      chk1("hold_fwd_switching", switching, 1'b0);
      chk1("hold_fwd_dn_valid", dn_valid, 1'b1);
    end
    @(posedge clk); #1;
    dn_ready = 1'b1;
    wait_sw();
    chk1("switch_dir_keeps_fwd", dir, 1'b0);
    chk1("switch_up_ready", up_ready, 1'b0);
    chk1("switch_bk_in_ready", bk_in_ready, 1'b0);
    @(negedge clk);
    chk1("switch_one_cycle", switching, 1'b0);
    chk1("bwd_dir", dir, 1'b1);
    chk1("bwd_bk_in_ready", bk_in_ready, 1'b1);
    chk1("bwd_up_ready", up_ready, 1'b0);
    chk16("inflight_before_return", inflight, 16'd6);

    // Backward return
    @(posedge clk); #1;
    bk_out_ready = 1'b1;
    push_bk(16'h1234, 16'h0F0F, 1'b1, 1'b0);
    chk1("bwd_latency_valid", bk_out_valid, 1'b1);
    chk("bwd_latency_tuple", {bk_out_a, bk_out_b, bk_out_c0, bk_out_z},
        pk(16'h1234, 16'h0F0F, 1'b1, 1'b0));
    chk16("inflight_after_return", inflight, 16'd5);
    drain();

    // Simultaneous read/write at count=1
    bk_out_ready = 1'b0;
    push_bk(16'h1111, 16'h2222, 1'b0, 1'b1);
    bk_out_ready = 1'b1;
    push_bk(16'h3333, 16'h4444, 1'b1, 1'b0);
    chk1("simul_still_valid", bk_out_valid, 1'b1);
    chk("simul_new_head", {bk_out_a, bk_out_b, bk_out_c0, bk_out_z},
        pk(16'h3333, 16'h4444, 1'b1, 1'b0));
    chk1("simul_not_full", bk_in_ready, 1'b1);
    drain();

    // Wrap: ten tuples through a two-entry FIFO
    for (int i = 0; i < 10; i++) begin
      logic [15:0] a;
      a = 16'(i + 256);
      push_bk(a, ~a, i[0], i[1]);
    end
    drain();
    chk16("inflight_wraps_below_zero", inflight, 16'hFFF9);

    // Back to forward, twelve more tuples bring inflight to 5
    dir_req = 1'b0;
    wait_sw();
    @(negedge clk);
    chk1("fwd_again_dir", dir, 1'b0);
    chk1("fwd_again_up_ready", up_ready, 1'b1);
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) begin
      logic [15:0] a;
      a = 16'(i * 4369 + 7);
      push_up(a, a ^ 16'h00FF, i[1], i[0]);
    end
    drain();
    chk16("inflight_five", inflight, 16'd5);

    // Asynchronous reset in the middle of SWITCH
    dir_req = 1'b1;
    wait_sw();
    rst = 1'b1;
    #1;
    chk1("mid_sw_rst_dir", dir, 1'b0);
    chk1("mid_sw_rst_switching", switching, 1'b0);
    chk16("mid_sw_rst_inflight", inflight, 16'h0000);
    chk1("mid_sw_rst_up_ready", up_ready, 1'b0);
    chk1("mid_sw_rst_dn_valid", dn_valid, 1'b0);
    chk1("mid_sw_rst_bk_in_ready", bk_in_ready, 1'b0);
    chk1("mid_sw_rst_bk_out_valid", bk_out_valid, 1'b0);
    dir_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk1("post_rst_up_ready", up_ready, 1'b1);
    chk1("post_rst_dir", dir, 1'b0);
    push_up(16'hDEAD, 16'hBEEF, 1'b1, 1'b1);
    drain();
    chk16("post_rst_inflight", inflight, 16'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
